// File: rtl/arm_regbank_pkg.sv
// rtl/arm_regbank_pkg.sv - mode codes and architectural-to-physical register map for the banked register file
package arm_regbank_pkg;

  localparam int PHYS_W   = 5;
  localparam int NUM_PHYS = 31;

  // Physical slot holding R15; slots 0..29 are general-purpose registers.
  localparam logic [PHYS_W-1:0] PHYS_PC = 5'd30;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  typedef enum logic [2:0] {
    BANK_USR,
    BANK_FIQ,
    BANK_IRQ,
    BANK_SVC,
    BANK_ABT,
    BANK_UND
  } bank_e;

  // SYS shares the USR view; unknown mode codes fall back to USR.
  function automatic bank_e mode_bank(input logic [4:0] mode);
    case (mode)
      MODE_FIQ: return BANK_FIQ;
      MODE_IRQ: return BANK_IRQ;
      MODE_SVC: return BANK_SVC;
      MODE_ABT: return BANK_ABT;
      MODE_UND: return BANK_UND;
      default:  return BANK_USR;
    endcase
  endfunction

  // Layout: 0..14 USR R0-R14, 15..21 FIQ R8-R14, 22/23 IRQ, 24/25 SVC,
  // 26/27 ABT, 28/29 UND R13-R14, 30 PC.
  function automatic logic [PHYS_W-1:0] phys_idx(input logic [4:0] mode,
                                                 input logic       user_bank,
                                                 input logic [3:0] arch_idx);
    bank_e             bank;
    logic [PHYS_W-1:0] a;
    a    = {1'b0, arch_idx};
    bank = user_bank ? BANK_USR : mode_bank(mode);
    if (arch_idx == 4'd15) return PHYS_PC;
    if (bank == BANK_FIQ && arch_idx >= 4'd8) return a + 5'd7;
    if (arch_idx >= 4'd13) begin
      case (bank)
        BANK_IRQ: return a + 5'd9;
        BANK_SVC: return a + 5'd11;
        BANK_ABT: return a + 5'd13;
        BANK_UND: return a + 5'd15;
        default:  return a;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/regbank_index_map.sv
// rtl/regbank_index_map.sv - combinational architectural-to-physical register index for one port
module regbank_index_map
  import arm_regbank_pkg::*;
(
  input  logic [4:0]        mode_i,
  input  logic              user_bank_i,
  input  logic [3:0]        arch_i,
  output logic [PHYS_W-1:0] phys_o
);

  assign phys_o = phys_idx(mode_i, user_bank_i, arch_i);

endmodule

// File: rtl/banked_reg_bank.sv
// rtl/banked_reg_bank.sv - banked ARMv4 register file with gated read buses, primary and writeback ports
module banked_reg_bank
  import arm_regbank_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  PC_RESET = 32'h3000,
  parameter int                 PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        MODE,
  input  logic              USER_BANK,
  input  logic [31:0]       IR,
  input  logic              RD_MUX,
  input  logic              DATA_MUX,
  input  logic              PC_MUX,
  input  logic              LATCH_REG,
  input  logic              LATCH_WB,
  input  logic [DATA_W-1:0] ALU_BUS,
  input  logic [DATA_W-1:0] MEM_BUS,
  input  logic [DATA_W-1:0] WB_BUS,
  input  logic              REG_GATE_A,
  input  logic              REG_GATE_B,
  input  logic              REG_GATE_C,
  output logic [DATA_W-1:0] A_BUS,
  output logic [DATA_W-1:0] B_BUS,
  output logic [DATA_W-1:0] C_BUS
);

  logic [DATA_W-1:0] regs_q [NUM_PHYS];
  logic [DATA_W-1:0] regs_d [NUM_PHYS];

  logic [3:0]        rn_arch;
  logic [3:0]        dest_arch;
  logic [PHYS_W-1:0] rn_phys;
  logic [PHYS_W-1:0] rm_phys;
  logic [PHYS_W-1:0] rs_phys;
  logic [PHYS_W-1:0] dest_phys;
  logic [DATA_W-1:0] wr_data;
  logic              primary_wr;
  logic              unused_ir;

  assign rn_arch    = IR[19:16];
  assign dest_arch  = RD_MUX ? IR[15:12] : IR[19:16];
  assign wr_data    = DATA_MUX ? ALU_BUS : MEM_BUS;
  assign primary_wr = LATCH_REG & ~PC_MUX;
  assign unused_ir  = ^{IR[31:20], IR[7:4]};

  regbank_index_map u_map_rn (
    .mode_i(MODE), .user_bank_i(USER_BANK), .arch_i(rn_arch), .phys_o(rn_phys)
  );
  regbank_index_map u_map_rm (
    .mode_i(MODE), .user_bank_i(USER_BANK), .arch_i(IR[3:0]), .phys_o(rm_phys)
  );
  regbank_index_map u_map_rs (
    .mode_i(MODE), .user_bank_i(USER_BANK), .arch_i(IR[11:8]), .phys_o(rs_phys)
  );
  regbank_index_map u_map_dest (
    .mode_i(MODE), .user_bank_i(USER_BANK), .arch_i(dest_arch), .phys_o(dest_phys)
  );

  // Next-state: PC increment or primary write first, then writeback unless it collides with the primary dest.
  always_comb begin
    regs_d = regs_q;
    if (LATCH_REG && PC_MUX) begin
      regs_d[PHYS_PC] = regs_q[PHYS_PC] + DATA_W'(PC_STEP);
    end else if (primary_wr) begin
      if (dest_phys == PHYS_PC) regs_d[PHYS_PC] = wr_data & ~DATA_W'(3);
      else                      regs_d[dest_phys] = wr_data;
    end
    if (LATCH_WB && rn_arch != 4'd15 && !(primary_wr && rn_phys == dest_phys)) begin
      regs_d[rn_phys] = WB_BUS;
    end
  end

  // Register storage; reset clears every bank and reloads the PC, overriding any write that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) regs_q[i] <= '0;
      regs_q[PHYS_PC] <= PC_RESET;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign A_BUS = REG_GATE_A ? regs_q[rn_phys] : {DATA_W{1'bz}};
  assign B_BUS = REG_GATE_B ? regs_q[rm_phys] : {DATA_W{1'bz}};
  assign C_BUS = REG_GATE_C ? regs_q[rs_phys] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_banked_reg_bank.sv
// tb/tb_banked_reg_bank.sv - scoreboard bench for the banked register file
module tb_banked_reg_bank;

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  MODE;
  logic        USER_BANK;
  logic [31:0] IR;
  logic        RD_MUX, DATA_MUX, PC_MUX, LATCH_REG, LATCH_WB;
  logic [31:0] ALU_BUS, MEM_BUS, WB_BUS;
  logic        REG_GATE_A, REG_GATE_B, REG_GATE_C;
  wire  [31:0] A_BUS, B_BUS, C_BUS;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got, exp;

  banked_reg_bank #(.DATA_W(32), .PC_RESET(32'h3000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .MODE(MODE), .USER_BANK(USER_BANK), .IR(IR),
    .RD_MUX(RD_MUX), .DATA_MUX(DATA_MUX), .PC_MUX(PC_MUX),
    .LATCH_REG(LATCH_REG), .LATCH_WB(LATCH_WB),
    .ALU_BUS(ALU_BUS), .MEM_BUS(MEM_BUS), .WB_BUS(WB_BUS),
    .REG_GATE_A(REG_GATE_A), .REG_GATE_B(REG_GATE_B), .REG_GATE_C(REG_GATE_C),
    .A_BUS(A_BUS), .B_BUS(B_BUS), .C_BUS(C_BUS)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; LATCH_REG = 1'b0; LATCH_WB = 1'b0; PC_MUX = 1'b0;
    RD_MUX = 1'b1; DATA_MUX = 1'b1; USER_BANK = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] mode, input logic ub, input logic [3:0] rd,
                          input logic [31:0] data, input logic dmux);
    MODE = mode; USER_BANK = ub; IR = {16'h0, rd, 12'h0};
    RD_MUX = 1'b1; DATA_MUX = dmux;
    ALU_BUS = dmux ? data : 32'hBAD0BAD0;
    MEM_BUS = dmux ? 32'hBAD1BAD1 : data;
    LATCH_REG = 1'b1;
    step();
    LATCH_REG = 1'b0; USER_BANK = 1'b0;
  endtask

  task automatic read_a(input logic [4:0] mode, input logic ub, input logic [3:0] rn,
                        output logic [31:0] v);
    MODE = mode; USER_BANK = ub; IR = {12'h0, rn, 16'h0}; REG_GATE_A = 1'b1;
    #2;
    v = A_BUS;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; MODE = M_USR; IR = 32'h000F0F0F;
    ALU_BUS = 0; MEM_BUS = 0; WB_BUS = 0;
    REG_GATE_A = 1'b1; REG_GATE_B = 1'b1; REG_GATE_C = 1'b1;
    step();
    exp_q.push_back(32'h3000);
    #2;
    exp = exp_q.pop_front();
    n_cmp++;
    if (A_BUS !== exp || B_BUS !== exp || C_BUS !== exp) begin
      n_bad++;
      $display("FAIL reset_pc_buses A=%h B=%h C=%h exp=%h", A_BUS, B_BUS, C_BUS, exp);
    end
    rst = 1'b0;
    IR = 32'h0;
    exp_q.push_back(32'h0);
    #2;
    exp = exp_q.pop_front();
    n_cmp++;
    if (A_BUS !== exp || B_BUS !== exp) begin
      n_bad++;
      $display("FAIL reset_r0 A=%h B=%h exp=%h", A_BUS, B_BUS, exp);
    end
    // Gates off with the PC selected everywhere: undriven buses are all-z (or 0 on a two-state simulator).
    IR = 32'h000F0F0F;
    REG_GATE_A = 1'b0; REG_GATE_B = 1'b0; REG_GATE_C = 1'b0;
    #2;
    n_cmp++;
    if (!((A_BUS === 32'hzzzzzzzz || A_BUS === 32'h0) &&
          (B_BUS === 32'hzzzzzzzz || B_BUS === 32'h0) &&
          (C_BUS === 32'hzzzzzzzz || C_BUS === 32'h0))) begin
      n_bad++;
      $display("FAIL gates_off A=%h B=%h C=%h exp=zzzzzzzz", A_BUS, B_BUS, C_BUS);
    end
  endtask

  task automatic test_pc_increment();
    idle();
    MODE = M_USR; IR = 32'h0; ALU_BUS = 32'hDEAD; PC_MUX = 1'b1; LATCH_REG = 1'b1;
    repeat (3) step();
    LATCH_REG = 1'b0;
    exp_q.push_back(32'h300C);
    read_a(M_USR, 1'b0, 4'd15, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL pc_inc3 got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0);
    read_a(M_USR, 1'b0, 4'd0, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL pc_inc_r0 got=%h exp=%h", got, exp); end
    step();
    PC_MUX = 1'b0;
    exp_q.push_back(32'h300C);
    read_a(M_USR, 1'b0, 4'd15, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL pc_hold got=%h exp=%h", got, exp); end
  endtask

  task automatic test_banking();
    idle();
    do_write(M_USR, 1'b0, 4'd13, 32'h1111, 1'b1);
    do_write(M_SVC, 1'b0, 4'd13, 32'h2222, 1'b1);
    do_write(M_IRQ, 1'b1, 4'd14, 32'h1414, 1'b1);
    exp_q.push_back(32'h2222);
    read_a(M_SVC, 1'b0, 4'd13, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL svc_r13 got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h1111);
    read_a(M_USR, 1'b0, 4'd13, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL usr_r13 got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h1111);
    read_a(M_SVC, 1'b1, 4'd13, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL svc_userbank_r13 got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h1414);
    read_a(M_USR, 1'b0, 4'd14, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL usr_r14_via_ub got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0);
    read_a(M_IRQ, 1'b0, 4'd14, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL irq_r14 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_fiq();
    idle();
    do_write(M_FIQ, 1'b0, 4'd8, 32'hF8, 1'b1);
    do_write(M_FIQ, 1'b0, 4'd7, 32'h77, 1'b0);
    exp_q.push_back(32'h0);
    read_a(M_USR, 1'b0, 4'd8, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL usr_r8 got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0);
    read_a(M_IRQ, 1'b0, 4'd8, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL irq_r8 got=%h exp=%h", got, exp); end
    exp_q.push_back(32'hF8);
    read_a(M_FIQ, 1'b0, 4'd8, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL fiq_r8 got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h77);
    read_a(M_USR, 1'b0, 4'd7, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL usr_r7_shared got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0);
    read_a(M_FIQ, 1'b0, 4'd13, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL fiq_r13 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_back_to_back();
    idle();
    MODE = M_USR;
    // Write visible only after the edge.
    IR = 32'h00044000; ALU_BUS = 32'h44; LATCH_REG = 1'b1; REG_GATE_A = 1'b1;
    exp_q.push_back(32'h0);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if (A_BUS !== exp) begin n_bad++; $display("FAIL no_forward got=%h exp=%h", A_BUS, exp); end
    step();
    LATCH_REG = 1'b0;
    exp_q.push_back(32'h44);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if (A_BUS !== exp) begin n_bad++; $display("FAIL after_edge got=%h exp=%h", A_BUS, exp); end
    // Primary and writeback to different registers.
    IR = 32'h00353000; ALU_BUS = 32'hA; WB_BUS = 32'hB; LATCH_REG = 1'b1; LATCH_WB = 1'b1;
    step();
    LATCH_REG = 1'b0; LATCH_WB = 1'b0;
    IR = 32'h00000503; REG_GATE_B = 1'b1; REG_GATE_C = 1'b1;
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if (B_BUS !== exp) begin n_bad++; $display("FAIL dual_r3 got=%h exp=%h", B_BUS, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (C_BUS !== exp) begin n_bad++; $display("FAIL dual_r5 got=%h exp=%h", C_BUS, exp); end
    // Same physical register: primary wins.
    IR = 32'h00055000; ALU_BUS = 32'hA; WB_BUS = 32'hB; LATCH_REG = 1'b1; LATCH_WB = 1'b1;
    step();
    LATCH_REG = 1'b0; LATCH_WB = 1'b0;
    exp_q.push_back(32'hA);
    read_a(M_USR, 1'b0, 4'd5, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL collide_r5 got=%h exp=%h", got, exp); end
    // Consecutive edges: R1 then R2 with writeback into R1.
    IR = 32'h00001000; ALU_BUS = 32'h101; LATCH_REG = 1'b1;
    step();
    IR = 32'h00012000; ALU_BUS = 32'h202; WB_BUS = 32'h111; LATCH_WB = 1'b1;
    step();
    LATCH_REG = 1'b0; LATCH_WB = 1'b0;
    IR = 32'h00000201;
    exp_q.push_back(32'h111);
    exp_q.push_back(32'h202);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if (B_BUS !== exp) begin n_bad++; $display("FAIL b2b_r1 got=%h exp=%h", B_BUS, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (C_BUS !== exp) begin n_bad++; $display("FAIL b2b_r2 got=%h exp=%h", C_BUS, exp); end
    // MUL layout: destination taken from IR[19:16].
    IR = 32'h00060000; RD_MUX = 1'b0; ALU_BUS = 32'h66; LATCH_REG = 1'b1;
    step();
    LATCH_REG = 1'b0; RD_MUX = 1'b1;
    IR = 32'h00000006;
    exp_q.push_back(32'h66);
    exp_q.push_back(32'h0);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if (B_BUS !== exp) begin n_bad++; $display("FAIL mul_dest_r6 got=%h exp=%h", B_BUS, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (C_BUS !== exp) begin n_bad++; $display("FAIL mul_r0_kept got=%h exp=%h", C_BUS, exp); end
    // Writeback to R15 is ignored.
    IR = 32'h000F0000; WB_BUS = 32'h1234; LATCH_WB = 1'b1;
    step();
    LATCH_WB = 1'b0;
    exp_q.push_back(32'h300C);
    read_a(M_USR, 1'b0, 4'd15, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL wb_r15_ignored got=%h exp=%h", got, exp); end
  endtask

  task automatic test_pc_write();
    idle();
    do_write(M_USR, 1'b0, 4'd15, 32'h4007, 1'b1);
    exp_q.push_back(32'h4004);
    read_a(M_USR, 1'b0, 4'd15, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL pc_write_mask got=%h exp=%h", got, exp); end
    do_write(M_USR, 1'b0, 4'd15, 32'hFFFFFFFC, 1'b1);
    PC_MUX = 1'b1; LATCH_REG = 1'b1;
    step();
    PC_MUX = 1'b0; LATCH_REG = 1'b0;
    exp_q.push_back(32'h0);
    read_a(M_USR, 1'b0, 4'd15, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL pc_wrap got=%h exp=%h", got, exp); end
    // Reset beats a simultaneous write and clears banked copies.
    rst = 1'b1;
    do_write(M_USR, 1'b0, 4'd1, 32'h55, 1'b1);
    rst = 1'b0;
    exp_q.push_back(32'h3000);
    read_a(M_USR, 1'b0, 4'd15, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL rst_pc got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0);
    read_a(M_USR, 1'b0, 4'd1, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL rst_write_dropped got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0);
    read_a(M_SVC, 1'b0, 4'd13, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL rst_svc_r13 got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0);
    read_a(M_FIQ, 1'b0, 4'd8, got);
    exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL rst_fiq_r8 got=%h exp=%h", got, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pc_increment();
    test_banking();
    test_fiq();
    test_back_to_back();
    test_pc_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
